// File: rtl/hedios_action_dispatcher_if.sv
// Dispatcher-side bundle: handler pending/ack vectors, consumer valid/ready command
// channel, and status (busy, sticky timeout error, dispatch counter).
interface hedios_action_dispatcher_if #(
  parameter int ACTION_COUNT = 8,
  parameter int ID_WIDTH     = 3
);
  logic [ACTION_COUNT-1:0] action_pending;
  logic [ACTION_COUNT-1:0] action_ack;
  logic                    cmd_valid;
  logic [ID_WIDTH-1:0]     cmd_id;
  logic                    cmd_ready;
  logic                    busy;
  logic                    timeout_err;
  logic                    err_clear;
  logic [15:0]             dispatch_count;

  modport master (
    input  action_pending, cmd_ready, err_clear,
    output action_ack, cmd_valid, cmd_id, busy, timeout_err, dispatch_count
  );

  modport slave (
    output action_pending, cmd_ready, err_clear,
    input  action_ack, cmd_valid, cmd_id, busy, timeout_err, dispatch_count
  );
endinterface

// File: rtl/hedios_action_dispatcher.sv
// Round-robin dispatcher: picks one pending HEDIOS action, offers its ID over valid/ready,
// then pulses a one-hot ack back to the handler. Optional handshake timeout with sticky error.
module hedios_action_dispatcher #(
  parameter int ACTION_COUNT = 8,
  parameter int ID_WIDTH     = 3,
  parameter int TIMEOUT      = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  hedios_action_dispatcher_if.master bus
);
  localparam int                  WAIT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [ID_WIDTH-1:0] LAST_IDX  = ID_WIDTH'(ACTION_COUNT - 1);
  localparam logic [WAIT_W-1:0]   WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;

  state_t              state;
  logic [ID_WIDTH-1:0] last_grant;
  logic [ID_WIDTH-1:0] next_grant;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                wait_expired;

  // First requester strictly after 'last', wrapping; only meaningful when req != 0.
  function automatic logic [ID_WIDTH-1:0] rr_pick(input logic [ACTION_COUNT-1:0] req,
                                                  input logic [ID_WIDTH-1:0]     last);
    logic [ID_WIDTH-1:0] cur;
    logic                found;
    cur     = last;
    found   = 1'b0;
    rr_pick = last;
    for (int k = 0; k < ACTION_COUNT; k++) begin
      cur = (cur == LAST_IDX) ? '0 : cur + ID_WIDTH'(1);
      if (!found && req[cur]) begin
        rr_pick = cur;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [ACTION_COUNT-1:0] one_hot(input logic [ID_WIDTH-1:0] id);
    one_hot     = '0;
    one_hot[id] = 1'b1;
  endfunction

  assign next_grant   = rr_pick(bus.action_pending, last_grant);
  // The wait counter holds the number of ready-less ISSUE cycles already spent.
  assign wait_expired = (TIMEOUT > 0) && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      last_grant         <= LAST_IDX;
      wait_cnt           <= '0;
      bus.cmd_valid      <= 1'b0;
      bus.cmd_id         <= '0;
      bus.action_ack     <= '0;
      bus.busy           <= 1'b0;
      bus.timeout_err    <= 1'b0;
      bus.dispatch_count <= '0;
    end else begin
      bus.action_ack <= '0;
      if (bus.err_clear) bus.timeout_err <= 1'b0;

      case (state)
        IDLE: begin
          if (|bus.action_pending) begin
            bus.cmd_id    <= next_grant;
            last_grant    <= next_grant;
            bus.cmd_valid <= 1'b1;
            bus.busy      <= 1'b1;
            wait_cnt      <= '0;
            state         <= ISSUE;
          end
        end

        ISSUE: begin
          if (bus.cmd_ready) begin
            bus.cmd_valid      <= 1'b0;
            bus.dispatch_count <= bus.dispatch_count + 16'd1;
            bus.action_ack     <= one_hot(bus.cmd_id);
            state              <= ACK;
          end else if (wait_expired) begin
            // Abandon the stalled dispatch but still ack so the handler flag clears.
            bus.cmd_valid  <= 1'b0;
            bus.action_ack <= one_hot(bus.cmd_id);
            if (!bus.err_clear) bus.timeout_err <= 1'b1;
            state          <= ACK;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        ACK: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hedios_action_dispatcher.sv
// Bench for hedios_action_dispatcher: two instances (no timeout / TIMEOUT=4) driven alike,
// with a handler model and a transaction-level dispatcher reference checked every cycle.
module tb_hedios_action_dispatcher;
  localparam int N  = 8;
  localparam int IW = 3;
  localparam int T1 = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hedios_action_dispatcher_if #(.ACTION_COUNT(N), .ID_WIDTH(IW)) bus0 ();
  hedios_action_dispatcher_if #(.ACTION_COUNT(N), .ID_WIDTH(IW)) bus1 ();

  hedios_action_dispatcher #(.ACTION_COUNT(N), .ID_WIDTH(IW), .TIMEOUT(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  hedios_action_dispatcher #(.ACTION_COUNT(N), .ID_WIDTH(IW), .TIMEOUT(T1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [N-1:0] trig;
  logic         ready;
  logic         eclr;

  // Reference state: handler flags plus what each dispatcher should show this cycle.
  int           tmo    [2] = '{0, T1};
  logic [N-1:0] pend   [2];
  logic [N-1:0] ack_m  [2];
  bit           valid_m[2];
  bit           in_ack [2];
  bit           err_m  [2];
  int           id_m   [2];
  int           last_m [2];
  int           wait_m [2];
  int           cnt_m  [2];

  int grants[$];
  int gcyc[$];
  bit prev_v = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr(input logic [N-1:0] p, input int last);
    logic [N-1:0] s;
    for (int k = 1; k <= N; k++) begin
      s = p >> ((last + k) % N);
      if (s[0]) return (last + k) % N;
    end
    return last;
  endfunction

  function automatic logic [N-1:0] oh(input int id);
    oh = N'(1) << id;
  endfunction

  task automatic step();
    logic [N-1:0] nxt [2];
    logic [31:0]  o   [6];
    logic [31:0]  e   [6];
    string        nm  [6] = '{"valid", "id", "ack", "busy", "err", "count"};
    bus0.action_pending = pend[0];
    bus1.action_pending = pend[1];
    bus0.cmd_ready      = ready;
    bus1.cmd_ready      = ready;
    bus0.err_clear      = eclr;
    bus1.err_clear      = eclr;
    for (int i = 0; i < 2; i++) begin
      // Handler: ack clears the flag unless the controller re-triggers it in the same cycle.
      nxt[i] = (pend[i] & ~ack_m[i]) | trig;
      if (rst) begin
        valid_m[i] = 1'b0; in_ack[i] = 1'b0; err_m[i] = 1'b0; id_m[i] = 0;
        last_m[i]  = N - 1; wait_m[i] = 0;   cnt_m[i] = 0;    ack_m[i] = '0;
      end else begin
        ack_m[i] = '0;
        if (eclr) err_m[i] = 1'b0;
        if (in_ack[i]) begin
          in_ack[i] = 1'b0;
        end else if (valid_m[i]) begin
          if (ready) begin
            valid_m[i] = 1'b0; cnt_m[i] = (cnt_m[i] + 1) % 65536;
            ack_m[i]   = oh(id_m[i]); in_ack[i] = 1'b1;
          end else if (tmo[i] > 0 && wait_m[i] + 1 == tmo[i]) begin
            valid_m[i] = 1'b0; if (!eclr) err_m[i] = 1'b1;
            ack_m[i]   = oh(id_m[i]); in_ack[i] = 1'b1;
          end else begin
            wait_m[i]++;
          end
        end else if (pend[i] != '0) begin
          id_m[i] = rr(pend[i], last_m[i]); last_m[i] = id_m[i];
          valid_m[i] = 1'b1; wait_m[i] = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    pend = nxt;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        o = '{32'(bus0.cmd_valid), 32'(bus0.cmd_id), 32'(bus0.action_ack), 32'(bus0.busy),
              32'(bus0.timeout_err), 32'(bus0.dispatch_count)};
      end else begin
        o = '{32'(bus1.cmd_valid), 32'(bus1.cmd_id), 32'(bus1.action_ack), 32'(bus1.busy),
              32'(bus1.timeout_err), 32'(bus1.dispatch_count)};
      end
      e = '{32'(valid_m[i]), 32'(id_m[i]), 32'(ack_m[i]), 32'(valid_m[i] | in_ack[i]),
            32'(err_m[i]), 32'(cnt_m[i])};
      for (int j = 0; j < 6; j++) chk($sformatf("d%0d_%s", i, nm[j]), o[j], e[j]);
    end
    if (bus0.cmd_valid && !prev_v) begin
      grants.push_back(int'(bus0.cmd_id));
      gcyc.push_back(cyc);
    end
    prev_v = bus0.cmd_valid;
  endtask

  initial begin
    int          vcnt;
    int          c0;
    bit          retrig_done;
    int          stall;
    int          exp_rt[4] = '{1, 4, 6, 1};

    pend  = '{default: '0};
    ack_m = '{default: '0};
    trig  = '0; ready = 1'b0; eclr = 1'b0; rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Single action, ready tied high.
    grants.delete(); gcyc.delete();
    ready = 1'b1; trig = 8'h04;
    step();
    trig = '0;
    repeat (5) step();
    chk("single_id", grants.size() > 0 ? grants[0] : -1, 2);
    chk("single_cnt", 32'(bus0.dispatch_count), 1);

    // Round-robin with every flag held.
    rst = 1'b1; step(); rst = 1'b0;
    grants.delete(); gcyc.delete();
    trig = 8'hFF;
    repeat (28) step();
    trig = '0;
    chk("rr_count", 32'(grants.size() >= 9), 1);
    for (int k = 0; k < grants.size() && k < 9; k++) chk($sformatf("rr_order%0d", k), grants[k], k % N);
    for (int k = 1; k < gcyc.size() && k < 9; k++) chk($sformatf("rr_space%0d", k), gcyc[k] - gcyc[k-1], 3);
    repeat (30) step();

    // Backpressure on action 5 for 10 cycles.
    ready = 1'b0; trig = 8'h20;
    step();
    trig = '0;
    for (int k = 0; k < 10 && !bus0.cmd_valid; k++) step();
    chk("bp_valid_seen", 32'(bus0.cmd_valid), 1);
    repeat (10) begin
      chk("bp_id", 32'(bus0.cmd_id), 5);
      chk("bp_valid", 32'(bus0.cmd_valid), 1);
      step();
    end
    ready = 1'b1;
    step();
    chk("bp_ack", 32'(bus0.action_ack), 32'h20);
    step();
    chk("bp_ack_done", 32'(bus0.action_ack), 0);
    eclr = 1'b1; step(); eclr = 1'b0;

    // Timeout on the TIMEOUT=4 instance, action 3, ready never given.
    ready = 1'b0; trig = 8'h08;
    step();
    trig = '0;
    c0 = cnt_m[1];
    vcnt = 0;
    for (int k = 0; k < 20 && bus1.action_ack == '0; k++) begin
      if (bus1.cmd_valid) vcnt++;
      step();
    end
    chk("to_ack", 32'(bus1.action_ack), 32'h08);
    chk("to_vcycles", vcnt, T1);
    chk("to_err", 32'(bus1.timeout_err), 1);
    chk("to_cnt", 32'(bus1.dispatch_count), c0);
    repeat (3) step();
    chk("to_sticky", 32'(bus1.timeout_err), 1);
    eclr = 1'b1; step(); eclr = 1'b0;
    chk("to_clear", 32'(bus1.timeout_err), 0);
    ready = 1'b1;
    repeat (6) step();

    // Re-trigger action 1 during its own ack cycle.
    rst = 1'b1; step(); rst = 1'b0;
    grants.delete(); gcyc.delete();
    trig = 8'b0101_0010;
    step();
    retrig_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      trig = '0;
      if (ack_m[0][1] && !retrig_done) begin
        trig = 8'h02;
        retrig_done = 1'b1;
      end
      step();
    end
    trig = '0;
    chk("rt_count", 32'(grants.size()), 4);
    for (int k = 0; k < 4; k++) chk($sformatf("rt_order%0d", k), k < grants.size() ? grants[k] : -1, exp_rt[k]);

    // Reset while a dispatch is waiting for ready.
    ready = 1'b0; trig = 8'h40;
    step();
    trig = '0;
    for (int k = 0; k < 5 && !bus0.cmd_valid; k++) step();
    chk("rst_valid_before", 32'(bus0.cmd_valid), 1);
    rst = 1'b1; trig = 8'h04;
    step();
    rst = 1'b0; trig = '0;
    chk("rst_valid", 32'(bus0.cmd_valid), 0);
    chk("rst_ack", 32'(bus0.action_ack), 0);
    chk("rst_busy", 32'(bus0.busy), 0);
    chk("rst_cnt", 32'(bus0.dispatch_count), 0);
    grants.delete(); gcyc.delete();
    ready = 1'b1;
    for (int k = 0; k < 10 && grants.size() == 0; k++) step();
    chk("rst_first", grants.size() > 0 ? grants[0] : -1, 2);
    repeat (8) step();

    // Randomized traffic with stalls, error clears and occasional resets.
    stall = 0;
    for (int k = 0; k < 1500; k++) begin
      trig = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      if (stall > 0) begin
        ready = 1'b0;
        stall--;
      end else begin
        ready = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 25) == 0) stall = $urandom_range(3, 8);
      end
      eclr = ($urandom_range(0, 40) == 0);
      rst  = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0; eclr = 1'b0; trig = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
